// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: arming delay, stimulus LED, 4-digit BCD
// millisecond counter stopped by the player, with early-press and timeout flags.
module reaction_timer_ctrl #(
    parameter int unsigned DELAY_MS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       onems,
    input  logic       start,
    input  logic       stop,
    output logic       tick_en,
    output logic       led,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       done,
    output logic       early,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [13:0] DLY_LAST = 14'(DELAY_MS - 1);

    state_t          state_q, state_d;
    logic            start_s_q, start_s_d;
    logic            start_prev_q, start_prev_d;
    logic            stop_s_q, stop_s_d;
    logic            stop_prev_q, stop_prev_d;
    logic [13:0]     dly_cnt_q, dly_cnt_d;
    logic [3:0][3:0] digits_q, digits_d;
    logic            led_q, led_d;
    logic            done_q, done_d;
    logic            early_q, early_d;
    logic            timeout_q, timeout_d;

    logic            start_p;
    logic            stop_p;
    logic [3:0][3:0] digits_inc;
    logic            all_nines;

    // Button edges come from the registered sample and its previous value,
    // so each pulse is exactly one cycle wide and glitch-free.
    assign start_p = start_s_q & ~start_prev_q;
    assign stop_p  = stop_s_q & ~stop_prev_q;

    assign tick_en = (state_q == DELAY) || (state_q == COUNT);

    assign led     = led_q;
    assign done    = done_q;
    assign early   = early_q;
    assign timeout = timeout_q;
    assign bcd3    = digits_q[3];
    assign bcd2    = digits_q[2];
    assign bcd1    = digits_q[1];
    assign bcd0    = digits_q[0];

    // Ripple BCD incrementer: a digit at 9 wraps to 0 and carries onward.
    always_comb begin
        logic carry;
        digits_inc = digits_q;
        carry      = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (digits_q[i] == 4'd9) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits_q[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        all_nines = (digits_q == 16'h9999);
    end

    // Next-state, counters and result flags.
    always_comb begin
        state_d      = state_q;
        start_s_d    = start;
        start_prev_d = start_s_q;
        stop_s_d     = stop;
        stop_prev_d  = stop_s_q;
        dly_cnt_d    = dly_cnt_q;
        digits_d     = digits_q;
        led_d        = led_q;
        done_d       = done_q;
        early_d      = early_q;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_p) begin
                    state_d   = DELAY;
                    dly_cnt_d = '0;
                    digits_d  = '0;
                    led_d     = 1'b0;
                    done_d    = 1'b0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            DELAY: begin
                if (stop_p) begin
                    state_d = DONE;
                    early_d = 1'b1;
                    done_d  = 1'b1;
                    led_d   = 1'b0;
                end else if (onems) begin
                    dly_cnt_d = dly_cnt_q + 14'd1;
                    if (dly_cnt_q == DLY_LAST) begin
                        state_d = COUNT;
                        led_d   = 1'b1;
                    end
                end
            end
            COUNT: begin
                if (stop_p) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    led_d   = 1'b0;
                end else if (onems) begin
                    if (all_nines) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        led_d     = 1'b0;
                    end else begin
                        digits_d = digits_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            start_s_q    <= 1'b0;
            start_prev_q <= 1'b0;
            stop_s_q     <= 1'b0;
            stop_prev_q  <= 1'b0;
            dly_cnt_q    <= '0;
            digits_q     <= '0;
            led_q        <= 1'b0;
            done_q       <= 1'b0;
            early_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_s_q    <= start_s_d;
            start_prev_q <= start_prev_d;
            stop_s_q     <= stop_s_d;
            stop_prev_q  <= stop_prev_d;
            dly_cnt_q    <= dly_cnt_d;
            digits_q     <= digits_d;
            led_q        <= led_d;
            done_q       <= done_d;
            early_q      <= early_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: vector table, directed corner sequences and
// random stimulus, all compared against an integer-count reference model.
module tb_reaction_timer_ctrl;

    localparam int unsigned DLY = 5;

    logic       clk = 1'b0;
    logic       rst, onems, start, stop;
    logic       tick_en, led, done, early, timeout;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(.DELAY_MS(DLY)) dut (
        .clk     (clk),
        .rst     (rst),
        .onems   (onems),
        .start   (start),
        .stop    (stop),
        .tick_en (tick_en),
        .led     (led),
        .bcd3    (bcd3),
        .bcd2    (bcd2),
        .bcd1    (bcd1),
        .bcd0    (bcd0),
        .done    (done),
        .early   (early),
        .timeout (timeout)
    );

    // Reference model: game phase plus an integer elapsed-ms count.
    localparam int PH_WAIT = 0, PH_ARM = 1, PH_RUN = 2, PH_OVER = 3;
    int m_phase, m_ticks, m_elapsed;
    bit m_led, m_done, m_early, m_timeout;
    bit ms_s, ms_p, mp_s, mp_p;
    bit hs = 1'b0;

    function automatic void model_edge(bit r, bit s, bit p, bit o);
        bit sp, pp;
        if (!r) begin
            m_phase = PH_WAIT; m_ticks = 0; m_elapsed = 0;
            m_led = 0; m_done = 0; m_early = 0; m_timeout = 0;
            ms_s = 0; ms_p = 0; mp_s = 0; mp_p = 0;
            return;
        end
        sp = ms_s && !ms_p;
        pp = mp_s && !mp_p;
        ms_p = ms_s; ms_s = s;
        mp_p = mp_s; mp_s = p;
        case (m_phase)
            PH_WAIT, PH_OVER: if (sp) begin
                m_phase = PH_ARM; m_ticks = 0; m_elapsed = 0;
                m_done = 0; m_early = 0; m_timeout = 0; m_led = 0;
            end
            PH_ARM: if (pp) begin
                m_phase = PH_OVER; m_early = 1; m_done = 1; m_led = 0;
            end else if (o) begin
                m_ticks++;
                if (m_ticks == int'(DLY)) begin
                    m_phase = PH_RUN; m_led = 1;
                end
            end
            PH_RUN: if (pp) begin
                m_phase = PH_OVER; m_done = 1; m_led = 0;
            end else if (o) begin
                if (m_elapsed == 9999) begin
                    m_phase = PH_OVER; m_timeout = 1; m_done = 1; m_led = 0;
                end else begin
                    m_elapsed++;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(int e);
        return 32'(((e / 1000) % 10) * 4096 + ((e / 100) % 10) * 256 +
                   ((e / 10) % 10) * 16 + (e % 10));
    endfunction

    function automatic logic [31:0] dut_digits();
        return {16'h0, bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_tick_en", 32'(tick_en), 32'(m_phase == PH_ARM || m_phase == PH_RUN));
        chk("model_led", 32'(led), 32'(m_led));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_early", 32'(early), 32'(m_early));
        chk("model_timeout", 32'(timeout), 32'(m_timeout));
        chk("model_digits", dut_digits(), to_bcd(m_elapsed));
    endtask

    // One clock: drive, let the edge happen, sample on the falling edge.
    task automatic step(bit r, bit s, bit p, bit o);
        rst = r; start = s; stop = p; onems = o;
        @(posedge clk);
        model_edge(r, s, p, o);
        @(negedge clk);
        compare_model();
    endtask

    task automatic press_start();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic press_stop(bit o);
        step(1, hs, 1, 0);
        step(1, hs, 0, o);
    endtask

    task automatic tick_gap(int gap);
        for (int g = 1; g < gap; g++) step(1, hs, 0, 0);
        step(1, hs, 0, 1);
    endtask

    typedef struct {
        bit r, s, p, o;
        bit te, ld, dn, ea, to;
        logic [31:0] dig;
    } vec_t;

    vec_t tbl[20];
    int   kk[6];
    logic [31:0] kv[6];

    initial begin
        tbl[0]  = '{0,1,1,1, 0,0,0,0,0, 32'h0000};
        tbl[1]  = '{1,1,0,0, 0,0,0,0,0, 32'h0000};
        tbl[2]  = '{1,1,0,0, 1,0,0,0,0, 32'h0000};
        tbl[3]  = '{1,1,0,1, 1,0,0,0,0, 32'h0000};
        tbl[4]  = '{1,1,0,1, 1,0,0,0,0, 32'h0000};
        tbl[5]  = '{1,1,1,0, 1,0,0,0,0, 32'h0000};
        tbl[6]  = '{1,1,1,1, 0,0,1,1,0, 32'h0000};
        tbl[7]  = '{1,0,0,1, 0,0,1,1,0, 32'h0000};
        tbl[8]  = '{1,1,1,0, 0,0,1,1,0, 32'h0000};
        tbl[9]  = '{1,1,1,0, 1,0,0,0,0, 32'h0000};
        tbl[10] = '{1,1,1,1, 1,0,0,0,0, 32'h0000};
        tbl[11] = '{1,1,1,1, 1,0,0,0,0, 32'h0000};
        tbl[12] = '{1,1,1,1, 1,0,0,0,0, 32'h0000};
        tbl[13] = '{1,1,1,1, 1,0,0,0,0, 32'h0000};
        tbl[14] = '{1,1,1,1, 1,1,0,0,0, 32'h0000};
        tbl[15] = '{1,1,1,1, 1,1,0,0,0, 32'h0001};
        tbl[16] = '{1,1,1,1, 1,1,0,0,0, 32'h0002};
        tbl[17] = '{1,1,0,0, 1,1,0,0,0, 32'h0002};
        tbl[18] = '{1,1,1,0, 1,1,0,0,0, 32'h0002};
        tbl[19] = '{1,1,1,1, 0,0,1,0,0, 32'h0002};
        kk = '{9, 10, 99, 100, 999, 1000};
        kv = '{32'h0009, 32'h0010, 32'h0099, 32'h0100, 32'h0999, 32'h1000};

        rst = 1'b0; start = 1'b0; stop = 1'b0; onems = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("reset_tick_en", 32'(tick_en), 0);
        chk("reset_led", 32'(led), 0);
        chk("reset_flags", {29'h0, done, early, timeout}, 0);
        chk("reset_digits", dut_digits(), 32'h0000);

        // Vector table: early press, both-edges rearm, held buttons, stop beats tick.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].o);
            chk($sformatf("tbl%0d_tick_en", i), 32'(tick_en), 32'(tbl[i].te));
            chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].ld));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_early", i), 32'(early), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
            chk($sformatf("tbl%0d_digits", i), dut_digits(), tbl[i].dig);
        end
        step(1, 0, 0, 0);

        // Normal run, tick every 10 cycles.
        press_start();
        for (int i = 0; i < 4; i++) tick_gap(10);
        chk("normal_led_before", 32'(led), 0);
        tick_gap(10);
        chk("normal_led_lit", 32'(led), 1);
        for (int i = 0; i < 37; i++) tick_gap(10);
        press_stop(0);
        chk("normal_digits", dut_digits(), 32'h0037);
        chk("normal_done", 32'(done), 1);
        chk("normal_led_off", 32'(led), 0);
        chk("normal_tick_en", 32'(tick_en), 0);

        // Early press after two delay ticks.
        press_start();
        tick_gap(3);
        tick_gap(3);
        press_stop(0);
        chk("early_flag", 32'(early), 1);
        chk("early_done", 32'(done), 1);
        chk("early_led", 32'(led), 0);
        chk("early_digits", dut_digits(), 32'h0000);

        // Stop coincident with a tick at 0041.
        press_start();
        for (int i = 0; i < int'(DLY) + 41; i++) tick_gap(1);
        press_stop(1);
        chk("sim_digits", dut_digits(), 32'h0041);
        chk("sim_done", 32'(done), 1);
        // Start and stop together in DONE rearms.
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("both_rearm_tick_en", 32'(tick_en), 1);
        chk("both_rearm_flags", {29'h0, done, early, timeout}, 0);
        chk("both_rearm_digits", dut_digits(), 32'h0000);
        step(1, 0, 0, 0);

        // Carry chain and timeout.
        for (int i = 0; i < int'(DLY); i++) tick_gap(1);
        for (int k = 1; k <= 9999; k++) begin
            tick_gap(1);
            for (int j = 0; j < 6; j++)
                if (k == kk[j]) chk($sformatf("carry_%0d", k), dut_digits(), kv[j]);
        end
        chk("full_digits", dut_digits(), 32'h9999);
        chk("full_no_timeout", 32'(timeout), 0);
        tick_gap(1);
        chk("timeout_digits", dut_digits(), 32'h9999);
        chk("timeout_flag", 32'(timeout), 1);
        chk("timeout_done", 32'(done), 1);
        chk("timeout_led", 32'(led), 0);
        tick_gap(1);
        chk("timeout_hold", dut_digits(), 32'h9999);

        // Reset in the middle of counting.
        press_start();
        for (int i = 0; i < int'(DLY) + 20; i++) tick_gap(1);
        step(0, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("midrst_tick_en", 32'(tick_en), 0);
        chk("midrst_outputs", {27'h0, led, done, early, timeout, 1'b0}, 0);
        chk("midrst_digits", dut_digits(), 32'h0000);
        step(1, 0, 0, 0);

        // Start held through a whole run arms exactly once.
        hs = 1'b1;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < int'(DLY) + 3; i++) tick_gap(2);
        press_stop(0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1);
        chk("held_no_rearm", 32'(tick_en), 0);
        chk("held_digits", dut_digits(), 32'h0003);
        hs = 1'b0;
        step(1, 0, 0, 0);
        press_start();
        chk("held_rearm", 32'(tick_en), 1);
        chk("held_rearm_done", 32'(done), 0);

        // Random stimulus against the model.
        begin
            bit rs, rp;
            rs = 0; rp = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) rs = ~rs;
                if ($urandom_range(0, 11) == 0) rp = ~rp;
                step(($urandom_range(0, 299) != 0), rs, rp, ($urandom_range(0, 2) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
